// File: rtl/hub75_pkg.sv
// hub75_pkg: channel indices, default geometry and row packing shared by HUB75 driver and receiver.
package hub75_pkg;
    localparam int HUB75_NUM_CH   = 6;
    localparam int HUB75_WIDTH    = 64;
    localparam int HUB75_ROW_BITS = 5;
    localparam int CH_R1 = 0;
    localparam int CH_G1 = 1;
    localparam int CH_B1 = 2;
    localparam int CH_R2 = 3;
    localparam int CH_G2 = 4;
    localparam int CH_B2 = 5;
    typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;
    // Channel ch occupies row_data[ch_lsb(ch, width) +: width]; bit width-1 is the first bit shifted.
    function automatic int ch_lsb(int ch, int width);
        return ch * width;
    endfunction
endpackage

// File: rtl/hub75_rx_if.sv
// hub75_rx_if: completed-row valid/ready stream from the HUB75 receiver.
interface hub75_rx_if #(
    parameter int WIDTH    = 64,
    parameter int ROW_BITS = 5
) ();
    logic                  row_valid;
    logic                  row_ready;
    logic [ROW_BITS-1:0]   row_addr;
    logic [6*WIDTH-1:0]    row_data;
    logic                  count_err;
    modport master (output row_valid, row_addr, row_data, count_err, input row_ready);
    modport slave  (input row_valid, row_addr, row_data, count_err, output row_ready);
endinterface

// File: rtl/hub75_in_sync.sv
// hub75_in_sync: 2-FF synchronizer plus previous-value register, giving level, rise and fall per bit.
module hub75_in_sync #(
    parameter int           N   = 1,
    parameter logic [N-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] lvl_o,
    output logic [N-1:0] rise_o,
    output logic [N-1:0] fall_o
);
    logic [N-1:0] s1_q, s2_q, prev_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= RST;
            s2_q   <= RST;
            prev_q <= RST;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end
    assign lvl_o  = s2_q;
    assign rise_o = s2_q & ~prev_q;
    assign fall_o = ~s2_q & prev_q;
endmodule

// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 panel-side capture, one row of six channels per latch on a valid/ready stream.
// Define HUB75_RX_ONTIME_EN to build the OE on-time counter; otherwise ontime/ontime_valid are 0.
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int WIDTH       = HUB75_WIDTH,
    parameter int ROW_BITS    = HUB75_ROW_BITS,
    parameter int ONTIME_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   h75_clk,
    input  logic                   h75_lat,
    input  logic                   h75_oe,
    input  logic                   h75_r1,
    input  logic                   h75_g1,
    input  logic                   h75_b1,
    input  logic                   h75_r2,
    input  logic                   h75_g2,
    input  logic                   h75_b2,
    input  logic [ROW_BITS-1:0]    h75_addr,
    hub75_rx_if.master             row,
    output logic                   overrun,
    output logic [ONTIME_BITS-1:0] ontime,
    output logic                   ontime_valid
);
    localparam int NI = 3 + HUB75_NUM_CH + ROW_BITS;
    localparam int CW = $clog2(WIDTH + 2);
    logic [NI-1:0] pins, lvl, rise, fall;
    logic [HUB75_NUM_CH-1:0] bits;
    logic [HUB75_NUM_CH-1:0][WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    buf_state_t buf_q;
    logic [ROW_BITS-1:0] addr_q;
    logic [6*WIDTH-1:0] data_q;
    logic err_q, ovr_q, unused_ok;
    assign pins = {h75_addr, h75_b2, h75_g2, h75_r2, h75_b1, h75_g1, h75_r1, h75_oe, h75_lat, h75_clk};
    hub75_in_sync #(.N(NI), .RST(NI'(3'b100))) u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (pins),
        .lvl_o  (lvl),
        .rise_o (rise),
        .fall_o (fall)
    );
    assign bits = lvl[3 +: HUB75_NUM_CH];
    // Shift is resolved before the latch so a same-cycle latch captures the new bit and count.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (rise[0]) begin
            for (int c = 0; c < HUB75_NUM_CH; c++) sr_d[c] = {sr_q[c][WIDTH-2:0], bits[c]};
            cnt_d = (cnt_q == CW'(WIDTH + 1)) ? cnt_q : cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            buf_q  <= BUF_EMPTY;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= rise[1] ? '0 : cnt_d;
            if (rise[1] && (buf_q == BUF_EMPTY || row.row_ready)) begin
                buf_q  <= BUF_FULL;
                addr_q <= lvl[NI-1 -: ROW_BITS];
                data_q <= sr_d;
                err_q  <= cnt_d != CW'(WIDTH);
            end else if (rise[1]) begin
                ovr_q <= 1'b1;
            end else if (row.row_ready) begin
                buf_q <= BUF_EMPTY;
            end
        end
    end
    assign row.row_valid = buf_q == BUF_FULL;
    assign row.row_addr  = addr_q;
    assign row.row_data  = data_q;
    assign row.count_err = err_q;
    assign overrun       = ovr_q;
`ifdef HUB75_RX_ONTIME_EN
    logic [ONTIME_BITS-1:0] oe_cnt_q, ontime_q;
    logic ontime_valid_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            oe_cnt_q       <= '0;
            ontime_q       <= '0;
            ontime_valid_q <= 1'b0;
        end else begin
            ontime_valid_q <= rise[2];
            if (rise[2]) begin
                ontime_q <= oe_cnt_q;
                oe_cnt_q <= '0;
            end else if (!lvl[2]) begin
                oe_cnt_q <= (&oe_cnt_q) ? oe_cnt_q : oe_cnt_q + 1'b1;
            end
        end
    end
    assign ontime       = ontime_q;
    assign ontime_valid = ontime_valid_q;
`else
    assign ontime       = '0;
    assign ontime_valid = 1'b0;
`endif
    assign unused_ok = ^{fall, rise, lvl[2:0]};
endmodule
